// File: rtl/shift_ctl_pkg.sv
// shift_ctl_pkg: shared widths, limits, state type and quiet-sample test for shift_ctl
package shift_ctl_pkg;
    localparam int DATA_W = 20;
    localparam int SHIFT_W = 4;
    localparam int HEAD_BITS = 3;
    localparam logic [SHIFT_W-1:0] SHIFT_MAX = 4'd15;
    typedef enum logic {HOLD, WATCH} state_t;
    function automatic logic is_quiet(input logic signed [DATA_W-1:0] d);
        return (&d[DATA_W-1 -: HEAD_BITS]) || !(|d[DATA_W-1 -: HEAD_BITS]);
    endfunction
endpackage

// File: rtl/shift_ctl_if.sv
// shift_ctl_if: shifter-side bus (sample stream in, shift out)
interface shift_ctl_if;
    import shift_ctl_pkg::*;
    logic strobe;
    logic signed [DATA_W-1:0] data;
    logic ovf;
    logic [SHIFT_W-1:0] shift;
    modport master(output strobe, data, ovf, input shift);
    modport slave(input strobe, data, ovf, output shift);
endinterface

// File: rtl/shift_ctl_win.sv
// shift_ctl_win: quiet-window sample counter and quiet-flag accumulator
module shift_ctl_win #(
    parameter int WIN_LEN = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    input  logic quiet,
    input  logic restart,
    output logic win_done,
    output logic win_quiet
);
    logic [15:0] cnt;
    logic flag;
    assign win_done = strobe && !restart && cnt == 16'(WIN_LEN - 1);
    assign win_quiet = flag && quiet;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            flag <= 1'b1;
        end else if (restart || win_done) begin
            cnt <= '0;
            flag <= 1'b1;
        end else if (strobe) begin
            cnt <= cnt + 16'd1;
            flag <= flag && quiet;
        end
    end
endmodule

// File: rtl/shift_ctl.sv
// shift_ctl: automatic shifter range controller; SHIFT_CTL_STATS_EN builds the step counters
module shift_ctl
    import shift_ctl_pkg::*;
#(
    parameter int WIN_LEN = 256,
    parameter int HOLD_LEN = 2,
    parameter int SHIFT_INIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    shift_ctl_if.slave bus,
    input  logic auto_en,
    input  logic [SHIFT_W-1:0] manual_shift,
    output logic step_up,
    output logic step_dn,
    output logic sat,
    output logic [15:0] up_count,
    output logic [15:0] dn_count
);
    state_t state, state_nx;
    logic [7:0] hold_q, hold_nx;
    logic [SHIFT_W-1:0] shift_q, shift_nx;
    logic sat_nx, up_nx, dn_nx, win_done, win_quiet, restart;
    // window only advances on clean WATCH samples; everything else rearms it
    assign restart = !auto_en || state != WATCH || (bus.strobe && bus.ovf);
    shift_ctl_win #(.WIN_LEN(WIN_LEN)) u_win (
        .clk(clk),
        .rst_n(rst_n),
        .strobe(bus.strobe && !bus.ovf),
        .quiet(is_quiet(bus.data)),
        .restart(restart),
        .win_done(win_done),
        .win_quiet(win_quiet)
    );
    always_comb begin
        state_nx = state;
        hold_nx = hold_q;
        shift_nx = shift_q;
        sat_nx = sat;
        up_nx = 1'b0;
        dn_nx = 1'b0;
        if (!auto_en) begin
            state_nx = HOLD;
            hold_nx = 8'(HOLD_LEN);
            shift_nx = manual_shift;
            sat_nx = 1'b0;
        end else if (bus.strobe && state == HOLD) begin
            hold_nx = hold_q - 8'd1;
            state_nx = hold_q == 8'd1 ? WATCH : HOLD;
        end else if (bus.strobe && bus.ovf) begin
            if (shift_q != SHIFT_MAX) begin
                shift_nx = shift_q + 4'd1;
                up_nx = 1'b1;
                state_nx = HOLD;
                hold_nx = 8'(HOLD_LEN);
            end else begin
                sat_nx = 1'b1;
            end
        end else if (win_done && win_quiet && shift_q != '0) begin
            shift_nx = shift_q - 4'd1;
            dn_nx = 1'b1;
            state_nx = HOLD;
            hold_nx = 8'(HOLD_LEN);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HOLD;
            hold_q <= 8'(HOLD_LEN);
            shift_q <= SHIFT_W'(SHIFT_INIT);
            sat <= 1'b0;
            step_up <= 1'b0;
            step_dn <= 1'b0;
        end else begin
            state <= state_nx;
            hold_q <= hold_nx;
            shift_q <= shift_nx;
            sat <= sat_nx;
            step_up <= up_nx;
            step_dn <= dn_nx;
        end
    end
    assign bus.shift = shift_q;
`ifdef SHIFT_CTL_STATS_EN
    logic [15:0] up_q, dn_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_q <= '0;
            dn_q <= '0;
        end else begin
            if (up_nx && up_q != 16'hFFFF) up_q <= up_q + 16'd1;
            if (dn_nx && dn_q != 16'hFFFF) dn_q <= dn_q + 16'd1;
        end
    end
    assign up_count = up_q;
    assign dn_count = dn_q;
`else
    assign up_count = '0;
    assign dn_count = '0;
`endif
endmodule
